wb_exc_csr: RTL and testbench

Exception commit and CSR state unit for the writeback stage. Priority-resolves a parametrised vector of synchronous exception sources plus a maskable interrupt, and commits the winning exception or an `ertn` into architectural CSR state: CRMD, PRMD, ECFG, ESTAT, ERA, BADV, EENTRY and an optional timer. It produces the pipeline flush and redirect target in the same cycle and serves the CSR read/write port for csr instructions.

---
 rtl/wb_exc_csr.sv | 263 ++++++++++++++++++++++++++
 tb/tb_wb_exc_csr.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_exc_csr.sv
// wb_exc_csr: writeback-stage exception commit and CSR state.
// Resolves the synchronous exception sources and the internal interrupt by
// priority. It commits the winning exception or an ertn into CRMD, PRMD,
// ESTAT, ERA and BADV. It also serves the CSR read/write port.
// Optional timer (TCFG/TVAL/TICLR, ESTAT.IS[11]) is built when the macro
// WB_EXC_TIMER_EN is defined; otherwise those registers read as zero.
module wb_exc_csr #(
  parameter int                    NSRC      = 6,
  parameter logic [(NSRC-1)*6-1:0] ECODE_TAB = {6'h0D, 6'h0C, 6'h0B, 6'h09, 6'h08},
  parameter logic [NSRC-1:0]       BADV_MASK = 6'b000110,
  parameter int                    TIMER_W   = 32   // 3..32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_valid,
  input  logic [31:0]     wb_pc,
  input  logic [31:0]     wb_badv,
  input  logic [NSRC-1:0] wb_exc,
  input  logic            wb_is_ertn,
  input  logic [7:0]      hw_int,
  input  logic            csr_we,
  input  logic [13:0]     csr_num,
  input  logic [31:0]     csr_wmask,
  input  logic [31:0]     csr_wdata,
  output logic [31:0]     csr_rdata,
  output logic            wb_ex,
  output logic [5:0]      wb_ecode,
  output logic [7:0]      wb_esubcode,
  output logic            exc_flush,
  output logic [31:0]     exc_target,
  output logic            has_int
);

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00C;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  // LIE bit 10 has no interrupt behind it and is hardwired to zero.
  localparam logic [12:0] LIE_WMASK  = 13'h1BFF;

  // Architectural state
  logic [1:0]  crmd_plv_q,   crmd_plv_d;
  logic        crmd_ie_q,    crmd_ie_d;
  logic [1:0]  prmd_pplv_q,  prmd_pplv_d;
  logic        prmd_pie_q,   prmd_pie_d;
  logic [12:0] ecfg_lie_q,   ecfg_lie_d;
  logic [1:0]  estat_sw_q,   estat_sw_d;
  logic [7:0]  estat_hw_q,   estat_hw_d;
  logic [5:0]  estat_ecode_q, estat_ecode_d;
  logic [8:0]  estat_esub_q, estat_esub_d;
  logic [31:0] era_q,        era_d;
  logic [31:0] badv_q,       badv_d;
  logic [25:0] eentry_q,     eentry_d;

  logic        ti_flag;

`ifdef WB_EXC_TIMER_EN
  logic [TIMER_W-1:0] tcfg_q, tcfg_d;
  logic [TIMER_W-1:0] tval_q, tval_d;
  logic               ti_q,   ti_d;
  logic               tcfg_wr, ticlr_wr, expire;
  assign ti_flag = ti_q;
`else
  assign ti_flag = 1'b0;
`endif

  // Source 0 is the internal interrupt; the external flag at bit 0 is dropped.
  logic unused_exc0;
  assign unused_exc0 = wb_exc[0];

  logic [12:0]     estat_is;
  logic [NSRC-1:0] src_vec;
  logic [5:0]      win_ecode;
  logic            win_badv;
  logic            ertn_fire;
  logic            csr_wr;
  logic [31:0]     wr_val;

  assign estat_is  = {1'b0, ti_flag, 1'b0, estat_hw_q, estat_sw_q};
  assign has_int   = crmd_ie_q & (|(estat_is & ecfg_lie_q));
  assign src_vec   = {wb_exc[NSRC-1:1], has_int};

  // Priority encode: scan from the lowest-priority source so the lowest
  // set index is the last to write and wins.
  always_comb begin
    win_ecode = 6'h00;
    win_badv  = 1'b0;
    for (int i = NSRC-1; i >= 1; i--) begin
      if (src_vec[i]) begin
        win_ecode = ECODE_TAB[(i-1)*6 +: 6];
        win_badv  = BADV_MASK[i];
      end
    end
    if (src_vec[0]) begin
      win_ecode = 6'h00;
      win_badv  = BADV_MASK[0];
    end
  end

  // ertn takes precedence over any exception flag on the same instruction.
  assign ertn_fire   = wb_valid & wb_is_ertn;
  assign wb_ex       = wb_valid & ~wb_is_ertn & (|src_vec);
  assign wb_ecode    = wb_ex ? win_ecode : 6'h00;
  assign wb_esubcode = 8'h00;
  assign exc_flush   = wb_ex | ertn_fire;
  assign exc_target  = wb_ex     ? {eentry_q, 6'b0} :
                       ertn_fire ? era_q            : 32'h0;

  // An excepting instruction never writes a CSR.
  assign csr_wr = csr_we & wb_valid & ~wb_ex;
  // csr_rdata is the current value of the addressed CSR, so it is the "old"
  // operand of the masked merge.
  assign wr_val = (csr_rdata & ~csr_wmask) | (csr_wdata & csr_wmask);

  // Combinational CSR read mux
  always_comb begin
    csr_rdata = 32'h0;
    case (csr_num)
      CSR_CRMD:   csr_rdata = {29'd0, crmd_ie_q, crmd_plv_q};
      CSR_PRMD:   csr_rdata = {29'd0, prmd_pie_q, prmd_pplv_q};
      CSR_ECFG:   csr_rdata = {19'd0, ecfg_lie_q};
      CSR_ESTAT:  csr_rdata = {1'b0, estat_esub_q, estat_ecode_q, 3'b000, estat_is};
      CSR_ERA:    csr_rdata = era_q;
      CSR_BADV:   csr_rdata = badv_q;
      CSR_EENTRY: csr_rdata = {eentry_q, 6'b0};
`ifdef WB_EXC_TIMER_EN
      CSR_TCFG:   csr_rdata = 32'(tcfg_q);
      CSR_TVAL:   csr_rdata = 32'(tval_q);
`endif
      default:    csr_rdata = 32'h0;
    endcase
  end

  // Next-state: software write first, then exception/ertn commit overrides.
  always_comb begin
    crmd_plv_d    = crmd_plv_q;
    crmd_ie_d     = crmd_ie_q;
    prmd_pplv_d   = prmd_pplv_q;
    prmd_pie_d    = prmd_pie_q;
    ecfg_lie_d    = ecfg_lie_q;
    estat_sw_d    = estat_sw_q;
    estat_hw_d    = hw_int;
    estat_ecode_d = estat_ecode_q;
    estat_esub_d  = estat_esub_q;
    era_d         = era_q;
    badv_d        = badv_q;
    eentry_d      = eentry_q;
`ifdef WB_EXC_TIMER_EN
    tcfg_d        = tcfg_q;
`endif

    if (csr_wr) begin
      case (csr_num)
        CSR_CRMD:   begin crmd_ie_d  = wr_val[2]; crmd_plv_d  = wr_val[1:0]; end
        CSR_PRMD:   begin prmd_pie_d = wr_val[2]; prmd_pplv_d = wr_val[1:0]; end
        CSR_ECFG:   ecfg_lie_d = wr_val[12:0] & LIE_WMASK;
        CSR_ESTAT:  estat_sw_d = wr_val[1:0];
        CSR_ERA:    era_d      = wr_val;
        CSR_BADV:   badv_d     = wr_val;
        CSR_EENTRY: eentry_d   = wr_val[31:6];
`ifdef WB_EXC_TIMER_EN
        CSR_TCFG:   tcfg_d     = wr_val[TIMER_W-1:0];
`endif
        default: ;
      endcase
    end

    if (wb_ex) begin
      prmd_pplv_d   = crmd_plv_q;
      prmd_pie_d    = crmd_ie_q;
      crmd_plv_d    = 2'b00;
      crmd_ie_d     = 1'b0;
      era_d         = wb_pc;
      estat_ecode_d = win_ecode;
      estat_esub_d  = {1'b0, wb_esubcode};
      if (win_badv) badv_d = wb_badv;
    end else if (ertn_fire) begin
      crmd_plv_d = prmd_pplv_q;
      crmd_ie_d  = prmd_pie_q;
    end
  end

`ifdef WB_EXC_TIMER_EN
  assign tcfg_wr  = csr_wr & (csr_num == CSR_TCFG);
  assign ticlr_wr = csr_wr & (csr_num == CSR_TICLR) & wr_val[0];
  assign expire   = tcfg_q[0] & (tval_q == '0);

  // Timer: a TCFG write reloads the counter and beats an expiry; TI set
  // beats a same-cycle TICLR clear.
  always_comb begin
    ti_d   = ti_q;
    tval_d = tval_q;
    if (ticlr_wr) ti_d = 1'b0;
    if (expire)   ti_d = 1'b1;
    if (tcfg_wr) begin
      tval_d = {wr_val[TIMER_W-1:2], 2'b00};
    end else if (expire) begin
      if (tcfg_q[1]) tval_d = {tcfg_q[TIMER_W-1:2], 2'b00};
    end else if (tcfg_q[0]) begin
      tval_d = tval_q - TIMER_W'(1);
    end
  end

  // One-shot expiry disables the timer unless software rewrote TCFG.
  logic tcfg_en_next;
  always_comb begin
    tcfg_en_next = tcfg_d[0];
    if (!tcfg_wr && expire && !tcfg_q[1]) tcfg_en_next = 1'b0;
  end

  // Timer registers; reset also stops any countdown in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcfg_q <= '0;
      tval_q <= '0;
      ti_q   <= 1'b0;
    end else begin
      tcfg_q <= {tcfg_d[TIMER_W-1:1], tcfg_en_next};
      tval_q <= tval_d;
      ti_q   <= ti_d;
    end
  end
`endif

  // Architectural CSR registers, all cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      crmd_plv_q    <= 2'b00;
      crmd_ie_q     <= 1'b0;
      prmd_pplv_q   <= 2'b00;
      prmd_pie_q    <= 1'b0;
      ecfg_lie_q    <= 13'h0;
      estat_sw_q    <= 2'b00;
      estat_hw_q    <= 8'h00;
      estat_ecode_q <= 6'h00;
      estat_esub_q  <= 9'h000;
      era_q         <= 32'h0;
      badv_q        <= 32'h0;
      eentry_q      <= 26'h0;
    end else begin
      crmd_plv_q    <= crmd_plv_d;
      crmd_ie_q     <= crmd_ie_d;
      prmd_pplv_q   <= prmd_pplv_d;
      prmd_pie_q    <= prmd_pie_d;
      ecfg_lie_q    <= ecfg_lie_d;
      estat_sw_q    <= estat_sw_d;
      estat_hw_q    <= estat_hw_d;
      estat_ecode_q <= estat_ecode_d;
      estat_esub_q  <= estat_esub_d;
      era_q         <= era_d;
      badv_q        <= badv_d;
      eentry_q      <= eentry_d;
    end
  end

endmodule

// File: tb/tb_wb_exc_csr.sv
// Directed self-checking bench for wb_exc_csr. Timer checks are built when
// WB_EXC_TIMER_EN is defined; otherwise the timer CSRs must read as zero.
module tb_wb_exc_csr;

  localparam logic [13:0] CRMD = 14'h000, PRMD = 14'h001, ECFG = 14'h004,
                          ESTAT = 14'h005, ERA = 14'h006, BADV = 14'h007,
                          EENTRY = 14'h00C, TCFG = 14'h041, TVAL = 14'h042,
                          TICLR = 14'h044;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [31:0] wb_badv;
  logic [5:0]  wb_exc;
  logic        wb_is_ertn;
  logic [7:0]  hw_int;
  logic        csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [7:0]  wb_esubcode;
  logic        exc_flush;
  logic [31:0] exc_target;
  logic        has_int;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  always #10 clk = ~clk;

  wb_exc_csr dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_badv(wb_badv), .wb_exc(wb_exc), .wb_is_ertn(wb_is_ertn),
    .hw_int(hw_int), .csr_we(csr_we), .csr_num(csr_num),
    .csr_wmask(csr_wmask), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
    .exc_flush(exc_flush), .exc_target(exc_target), .has_int(has_int)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid = 1'b0; wb_is_ertn = 1'b0; wb_exc = 6'b0;
    csr_we = 1'b0; csr_wmask = 32'h0; csr_wdata = 32'h0;
  endtask

  task automatic wr(input logic [13:0] n, input logic [31:0] d, input logic [31:0] m);
    csr_num = n; csr_wdata = d; csr_wmask = m; csr_we = 1'b1; wb_valid = 1'b1;
    tick();
    idle();
  endtask

  task automatic rdchk(input string tag, input logic [13:0] n, input logic [31:0] exp);
    csr_num = n;
    #1;
    chk(tag, csr_rdata, exp);
  endtask

  task automatic tichk(input string tag, input logic exp);
    csr_num = ESTAT;
    #1;
    chk(tag, {31'd0, csr_rdata[11]}, {31'd0, exp});
  endtask

  initial begin
    idle();
    reset = 1'b1; hw_int = 8'h00; csr_num = 14'h0; wb_pc = 32'h0; wb_badv = 32'h0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_wb_ex", {31'd0, wb_ex}, 32'd0);
    chk("rst_has_int", {31'd0, has_int}, 32'd0);
    chk("rst_flush", {31'd0, exc_flush}, 32'd0);
    rdchk("rst_crmd", CRMD, 32'h0);
    rdchk("rst_estat", ESTAT, 32'h0);
    rdchk("rst_era", ERA, 32'h0);

    // Priority: ALE (src2) beats BRK (src4), ALE writes BADV
    wr(CRMD, 32'h3, 32'h7);
    rdchk("crmd_plv3", CRMD, 32'h3);
    wb_valid = 1'b1; wb_exc = 6'b010100; wb_pc = 32'h1c00_0040; wb_badv = 32'hdead_beef;
    #1;
    chk("ale_wb_ex", {31'd0, wb_ex}, 32'd1);
    chk("ale_ecode", {26'd0, wb_ecode}, 32'h09);
    chk("ale_esub", {24'd0, wb_esubcode}, 32'h0);
    chk("ale_flush", {31'd0, exc_flush}, 32'd1);
    chk("ale_target", exc_target, 32'h0);
    tick(); idle();
    rdchk("ale_era", ERA, 32'h1c00_0040);
    rdchk("ale_badv", BADV, 32'hdead_beef);
    rdchk("ale_crmd", CRMD, 32'h0);
    rdchk("ale_prmd", PRMD, 32'h3);
    rdchk("ale_estat", ESTAT, 32'h0009_0000);

    // SYS (src3) beats INE (src5); SYS leaves BADV alone
    wb_valid = 1'b1; wb_exc = 6'b101000; wb_pc = 32'h1c00_0080; wb_badv = 32'h1234_5678;
    #1;
    chk("sys_ecode", {26'd0, wb_ecode}, 32'h0B);
    tick(); idle();
    rdchk("sys_badv", BADV, 32'hdead_beef);
    rdchk("sys_era", ERA, 32'h1c00_0080);
    rdchk("sys_estat", ESTAT, 32'h000B_0000);

    // External bit 0 is ignored
    wb_valid = 1'b1; wb_exc = 6'b000001;
    #1;
    chk("bit0_wb_ex", {31'd0, wb_ex}, 32'd0);
    chk("bit0_flush", {31'd0, exc_flush}, 32'd0);
    idle();

    // ertn with an exception flag: treated as ertn
    wb_valid = 1'b1; wb_is_ertn = 1'b1; wb_exc = 6'b000010;
    #1;
    chk("ertnx_wb_ex", {31'd0, wb_ex}, 32'd0);
    chk("ertnx_flush", {31'd0, exc_flush}, 32'd1);
    chk("ertnx_target", exc_target, 32'h1c00_0080);
    idle();

    // EENTRY low bits and ECFG bit 10 are read-only zero
    wr(EENTRY, 32'h1c00_8fff, 32'hffff_ffff);
    rdchk("eentry_ro", EENTRY, 32'h1c00_8fc0);
    wr(ECFG, 32'hffff_ffff, 32'hffff_ffff);
    rdchk("ecfg_bit10", ECFG, 32'h0000_1BFF);

    // Masked write
    wr(CRMD, 32'hffff_ffff, 32'h4);
    rdchk("mw_crmd", CRMD, 32'h4);
    wr(CRMD, 32'h0, 32'hffff_ffff);
    rdchk("mw_crmd0", CRMD, 32'h0);
    csr_num = CRMD; csr_wdata = 32'hffff_ffff; csr_wmask = 32'h4; csr_we = 1'b1;
    wb_valid = 1'b1; wb_exc = 6'b000010; wb_pc = 32'h1c00_00c0; wb_badv = 32'h1c00_00c0;
    #1;
    chk("adef_ecode", {26'd0, wb_ecode}, 32'h08);
    chk("adef_target", exc_target, 32'h1c00_8fc0);
    tick(); idle();
    rdchk("adef_crmd", CRMD, 32'h0);
    csr_num = ECFG; csr_wdata = 32'h0; csr_wmask = 32'hffff_ffff; csr_we = 1'b1;
    wb_valid = 1'b1; wb_exc = 6'b000010; wb_pc = 32'h1c00_00c4; wb_badv = 32'h1c00_00c4;
    tick(); idle();
    rdchk("adef_ecfg", ECFG, 32'h0000_1BFF);
    rdchk("adef_badv", BADV, 32'h1c00_00c4);
    rdchk("adef_estat", ESTAT, 32'h0008_0000);

    // Interrupt
    wr(ECFG, 32'h4, 32'hffff_ffff);
    wr(CRMD, 32'h4, 32'h4);
    hw_int = 8'h01;
    #1;
    chk("int_before", {31'd0, has_int}, 32'd0);
    tick(); tick();
    chk("int_pending", {31'd0, has_int}, 32'd1);
    rdchk("int_estat", ESTAT, 32'h0008_0004);
    wb_valid = 1'b1; wb_exc = 6'b0; wb_pc = 32'h1c00_0200; wb_badv = 32'hffff_ffff;
    #1;
    chk("int_wb_ex", {31'd0, wb_ex}, 32'd1);
    chk("int_ecode", {26'd0, wb_ecode}, 32'h00);
    chk("int_target", exc_target, 32'h1c00_8fc0);
    tick(); idle(); hw_int = 8'h00;
    rdchk("int_badv", BADV, 32'h1c00_00c4);
    rdchk("int_era", ERA, 32'h1c00_0200);
    rdchk("int_crmd", CRMD, 32'h0);
    rdchk("int_prmd", PRMD, 32'h4);
    rdchk("int_estat2", ESTAT, 32'h0000_0004);
    chk("int_masked", {31'd0, has_int}, 32'd0);

    // ertn
    wr(PRMD, 32'h7, 32'h7);
    wr(ERA, 32'h1c00_0100, 32'hffff_ffff);
    wb_valid = 1'b1; wb_is_ertn = 1'b1;
    #1;
    chk("ertn_target", exc_target, 32'h1c00_0100);
    chk("ertn_flush", {31'd0, exc_flush}, 32'd1);
    chk("ertn_wb_ex", {31'd0, wb_ex}, 32'd0);
    tick(); idle();
    rdchk("ertn_crmd", CRMD, 32'h7);

`ifdef WB_EXC_TIMER_EN
    // Periodic timer: InitVal=2 -> TVAL=8, TI 9 edges after the write
    wr(TCFG, 32'h0000_000B, 32'hffff_ffff);
    rdchk("tm_tval8", TVAL, 32'd8);
    rdchk("tm_tcfg", TCFG, 32'h0000_000B);
    repeat (8) tick();
    rdchk("tm_tval0", TVAL, 32'd0);
    tichk("tm_ti_early", 1'b0);
    tick();
    tichk("tm_ti_set", 1'b1);
    rdchk("tm_reload", TVAL, 32'd8);
    wr(TICLR, 32'h1, 32'h1);
    tichk("tm_ticlr", 1'b0);
    rdchk("tm_tval7", TVAL, 32'd7);
    rdchk("tm_ticlr_rd", TICLR, 32'h0);
    // TICLR on the expiry edge: set wins
    repeat (7) tick();
    wr(TICLR, 32'h1, 32'h1);
    tichk("tm_setwins", 1'b1);
    rdchk("tm_reload2", TVAL, 32'd8);
    // TCFG write on the expiry edge: write wins for TVAL, TI still set
    wr(TICLR, 32'h1, 32'h1);
    repeat (7) tick();
    rdchk("tm_pre_wr", TVAL, 32'd0);
    wr(TCFG, 32'h0000_0011, 32'hffff_ffff);
    rdchk("tm_wrwins", TVAL, 32'd16);
    tichk("tm_wr_ti", 1'b1);
    // One-shot expiry disables the timer
    wr(TICLR, 32'h1, 32'h1);
    repeat (15) tick();
    tichk("tm_os_early", 1'b0);
    tick();
    tichk("tm_os_ti", 1'b1);
    rdchk("tm_os_en", TCFG, 32'h0000_0010);
    tick();
    rdchk("tm_os_hold", TVAL, 32'd0);
    // Reset during countdown
    wr(TICLR, 32'h1, 32'h1);
    wr(TCFG, 32'h0000_000B, 32'hffff_ffff);
    repeat (3) tick();
    rdchk("tm_tval5", TVAL, 32'd5);
`else
    wr(TCFG, 32'h0000_000B, 32'hffff_ffff);
    rdchk("nt_tcfg", TCFG, 32'h0);
    rdchk("nt_tval", TVAL, 32'h0);
    repeat (12) tick();
    tichk("nt_ti", 1'b0);
`endif

    reset = 1'b1;
    tick();
    reset = 1'b0;
    rdchk("rst2_crmd", CRMD, 32'h0);
    rdchk("rst2_era", ERA, 32'h0);
    rdchk("rst2_estat", ESTAT, 32'h0);
    rdchk("rst2_tval", TVAL, 32'h0);
    rdchk("rst2_tcfg", TCFG, 32'h0);
    repeat (12) tick();
    rdchk("rst2_estat_late", ESTAT, 32'h0);
    rdchk("rst2_tval_late", TVAL, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
